cdb_rr_arbiter: RTL

Registered round-robin arbiter that owns the common data bus. It replaces fixed-priority combinational ownership.
- ALU, LSM and BRA requesters hold req plus payload until granted.
- One winner per cycle is captured into a broadcast register driven to ROB, PC and all reservation stations.
- Guarantees bounded wait for every source.
- Provides a flush path for branch mispredict recovery.

---
 rtl/cdb_rr_arbiter_pkg.sv | 19 +
 rtl/cdb_rr_pick.sv | 37 +++
 rtl/cdb_rr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared constants, source codes and the circular-successor helper for the CDB arbiter.
package cdb_rr_arbiter_pkg;

    localparam int REG_LOCK_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int REG_NO_LOCK    = 0;

    localparam logic [1:0] CDB_SRC_NONE = 2'd0;
    localparam logic [1:0] CDB_SRC_ALU  = 2'd1;
    localparam logic [1:0] CDB_SRC_LSM  = 2'd2;
    localparam logic [1:0] CDB_SRC_BRA  = 2'd3;

    // Next source in the ALU->LSM->BRA ring; NONE maps onto ALU.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == CDB_SRC_BRA) ? CDB_SRC_ALU : s + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin pick over ALU/LSM/BRA (eligible bit 0 = ALU),
// with an optional BRA-always-wins mode.
module cdb_rr_pick
    import cdb_rr_arbiter_pkg::*;
(
    input  logic [2:0] eligible_i,
    input  logic [1:0] last_winner_i,
    input  logic       bra_prio_i,
    output logic [1:0] winner_o,
    output logic       any_o
);

    logic [2:0] pool;
    logic [1:0] cand;
    logic       found;

    always_comb begin
        winner_o = CDB_SRC_NONE;
        any_o    = |eligible_i;
        pool     = bra_prio_i ? {1'b0, eligible_i[1:0]} : eligible_i;
        cand     = last_winner_i;
        found    = 1'b0;
        if (bra_prio_i && eligible_i[2]) begin
            winner_o = CDB_SRC_BRA;
        end else begin
            // Walk the ring starting just after the last winner.
            for (int k = 0; k < 3; k++) begin
                cand = next_src(cand);
                if (!found && pool[cand - 2'd1]) begin
                    winner_o = cand;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Registered round-robin owner of the common data bus.
// Build option: define CDB_BRA_PRIO_EN to let an eligible BRA always win.
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int LOCK_W  = REG_LOCK_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int NO_LOCK = REG_NO_LOCK
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              alu_req_i,
    output logic              alu_grnt_o,
    input  logic [LOCK_W-1:0] alu_in_index_i,
    input  logic [DATA_W-1:0] alu_in_data_i,
    input  logic              lsm_req_i,
    output logic              lsm_grnt_o,
    input  logic [LOCK_W-1:0] lsm_in_index_i,
    input  logic [DATA_W-1:0] lsm_in_data_i,
    input  logic [ADDR_W-1:0] lsm_in_addr_i,
    input  logic              bra_req_i,
    output logic              bra_grnt_o,
    input  logic [LOCK_W-1:0] bra_in_index_i,
    input  logic [DATA_W-1:0] bra_in_data_i,
    output logic              out_valid_o,
    output logic [1:0]        out_src_o,
    output logic              out_is_branch_o,
    output logic [LOCK_W-1:0] out_index_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o
);

`ifdef CDB_BRA_PRIO_EN
    localparam logic BRA_PRIO = 1'b1;
`else
    localparam logic BRA_PRIO = 1'b0;
`endif

    localparam logic [LOCK_W-1:0] NO_TAG = LOCK_W'(NO_LOCK);

    logic [2:0]        req_vec;
    logic [2:0]        eligible;
    logic [1:0]        winner;
    logic              any;
    logic [LOCK_W-1:0] win_index;
    logic [DATA_W-1:0] win_data;
    logic [ADDR_W-1:0] win_addr;

    logic [2:0]        grnt_q,  grnt_d;
    logic [1:0]        last_q,  last_d;
    logic              valid_q, valid_d;
    logic [1:0]        src_q,   src_d;
    logic              br_q,    br_d;
    logic [LOCK_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    assign req_vec = {bra_req_i, lsm_req_i, alu_req_i};

    // A source granted last cycle still shows its old req/payload, so mask it.
    for (genvar gi = 0; gi < 3; gi++) begin : g_elig
        assign eligible[gi] = req_vec[gi] & ~grnt_q[gi];
    end

    cdb_rr_pick u_pick (
        .eligible_i    (eligible),
        .last_winner_i (last_q),
        .bra_prio_i    (BRA_PRIO),
        .winner_o      (winner),
        .any_o         (any)
    );

    always_comb begin
        win_index = NO_TAG;
        win_data  = '0;
        win_addr  = '0;
        case (winner)
            CDB_SRC_ALU: begin
                win_index = alu_in_index_i;
                win_data  = alu_in_data_i;
            end
            CDB_SRC_LSM: begin
                win_index = lsm_in_index_i;
                win_data  = lsm_in_data_i;
                win_addr  = lsm_in_addr_i;
            end
            CDB_SRC_BRA: begin
                win_index = bra_in_index_i;
                win_data  = bra_in_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        grnt_d  = '0;
        last_d  = last_q;
        valid_d = 1'b0;
        src_d   = CDB_SRC_NONE;
        br_d    = 1'b0;
        index_d = NO_TAG;
        data_d  = data_q;
        addr_d  = addr_q;
        if (!flush_i && any) begin
            grnt_d[winner - 2'd1] = 1'b1;
            src_d   = winner;
            br_d    = (winner == CDB_SRC_BRA);
            index_d = win_index;
            valid_d = (win_index != NO_TAG);
            data_d  = win_data;
            addr_d  = win_addr;
            // In priority mode a BRA win leaves the ALU/LSM rotation untouched.
            if (!(BRA_PRIO && winner == CDB_SRC_BRA)) begin
                last_d = winner;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grnt_q  <= '0;
            last_q  <= CDB_SRC_BRA;
            valid_q <= 1'b0;
            src_q   <= CDB_SRC_NONE;
            br_q    <= 1'b0;
            index_q <= NO_TAG;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            grnt_q  <= grnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            br_q    <= br_d;
            index_q <= index_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign alu_grnt_o      = grnt_q[0];
    assign lsm_grnt_o      = grnt_q[1];
    assign bra_grnt_o      = grnt_q[2];
    assign out_valid_o     = valid_q;
    assign out_src_o       = src_q;
    assign out_is_branch_o = br_q;
    assign out_index_o     = index_q;
    assign out_data_o      = data_q;
    assign out_addr_o      = addr_q;

endmodule
